conv_stream_engine: RTL

- Parametrised, command-driven convolution coprocessor. One instance runs one convolution layer.
- Does not take whole images and filters as flat buses. It fetches image and filter words from external synchronous ROM/RAM through address ports, and accumulates each output pixel in one multiply-accumulate datapath.
- Writes each saturated, optionally ReLU'd result to an output RAM.
- Sits between the host command byte and the layer memories. Signals busy, a one-cycle done pulse and a held finish flag.

---
 rtl/conv_stream_engine_if.sv | 41 ++++
 rtl/conv_stream_engine.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/conv_stream_engine_if.sv
// rtl/conv_stream_engine_if.sv - host command, layer-memory and result ports of the convolution engine
interface conv_stream_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 5,
  parameter int DEPTH      = 6,
  parameter int NUM_KERNEL = 16
);
  localparam int N      = DEPTH * K * K;
  localparam int IMG_SZ = DEPTH * IMG_H * IMG_W;
  localparam int FLT_SZ = NUM_KERNEL * N;
  localparam int RES_SZ = NUM_KERNEL * (IMG_H - K + 1) * (IMG_W - K + 1);
  localparam int IMG_AW = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1;
  localparam int FLT_AW = (FLT_SZ > 1) ? $clog2(FLT_SZ) : 1;
  localparam int RES_AW = (RES_SZ > 1) ? $clog2(RES_SZ) : 1;

  logic [7:0]            command;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IMG_AW-1:0]     img_addr;
  logic [DATA_WIDTH-1:0] img_data;
  logic [FLT_AW-1:0]     flt_addr;
  logic [DATA_WIDTH-1:0] flt_data;
  logic                  res_we;
  logic [RES_AW-1:0]     res_addr;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  busy;
  logic                  done;
  logic                  finish;

  modport master (
    output command, cmd_valid, img_data, flt_data,
    input  cmd_ready, img_addr, flt_addr, res_we, res_addr, res_data, busy, done, finish
  );

  modport slave (
    input  command, cmd_valid, img_data, flt_data,
    output cmd_ready, img_addr, flt_addr, res_we, res_addr, res_data, busy, done, finish
  );
endinterface

// File: rtl/conv_stream_engine.sv
// rtl/conv_stream_engine.sv - command-driven convolution layer engine with a single MAC datapath
module conv_stream_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int K          = 5,
  parameter int DEPTH      = 6,
  parameter int NUM_KERNEL = 16,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  conv_stream_engine_if.slave  bus
);
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;
  localparam int N      = DEPTH * K * K;
  localparam int IMG_SZ = DEPTH * IMG_H * IMG_W;
  localparam int FLT_SZ = NUM_KERNEL * N;
  localparam int RES_SZ = NUM_KERNEL * OUT_H * OUT_W;
  localparam int IMG_AW = (IMG_SZ > 1) ? $clog2(IMG_SZ) : 1;
  localparam int FLT_AW = (FLT_SZ > 1) ? $clog2(FLT_SZ) : 1;
  localparam int RES_AW = (RES_SZ > 1) ? $clog2(RES_SZ) : 1;
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int CW     = 16;

  localparam logic [CW-1:0] K_MAX  = CW'(K - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] OX_MAX = CW'(OUT_W - 1);
  localparam logic [CW-1:0] OY_MAX = CW'(OUT_H - 1);
  localparam logic [CW-1:0] KN_MAX = CW'(NUM_KERNEL - 1);

  localparam logic [31:0] W32   = 32'(IMG_W);
  localparam logic [31:0] HW32  = 32'(IMG_H * IMG_W);
  localparam logic [31:0] K32   = 32'(K);
  localparam logic [31:0] KK32  = 32'(K * K);
  localparam logic [31:0] N32   = 32'(N);
  localparam logic [31:0] OW32  = 32'(OUT_W);
  localparam logic [31:0] OHW32 = 32'(OUT_H * OUT_W);

  localparam logic [7:0] CMD_START      = 8'h01;
  localparam logic [7:0] CMD_START_RELU = 8'h02;
  localparam logic [7:0] CMD_ABORT      = 8'hFF;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] kx_q, ky_q, ch_q, ox_q, oy_q, kn_q;
  logic relu_q, vld_q, first_q, done_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext, shifted;
  logic abort, idle_like, accept, last_tap, last_out;

  assign abort     = bus.cmd_valid && (bus.command == CMD_ABORT);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = idle_like && bus.cmd_valid &&
                     ((bus.command == CMD_START) || (bus.command == CMD_START_RELU));
  assign last_tap  = (kx_q == K_MAX) && (ky_q == K_MAX) && (ch_q == C_MAX);
  assign last_out  = (ox_q == OX_MAX) && (oy_q == OY_MAX) && (kn_q == KN_MAX);

  // Addresses are pure functions of the loop counters, so they hold whenever the counters do.
  assign bus.img_addr = IMG_AW'(32'(ch_q) * HW32 + (32'(oy_q) + 32'(ky_q)) * W32 + 32'(ox_q) + 32'(kx_q));
  assign bus.flt_addr = FLT_AW'(32'(kn_q) * N32 + 32'(ch_q) * KK32 + 32'(ky_q) * K32 + 32'(kx_q));
  assign bus.res_addr = RES_AW'(32'(kn_q) * OHW32 + 32'(oy_q) * OW32 + 32'(ox_q));

  assign prod     = PW'($signed(bus.img_data)) * PW'($signed(bus.flt_data));
  assign prod_ext = ACC_WIDTH'(prod);
  assign shifted  = acc_q >>> OUT_SHIFT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (accept) state_d = S_ISSUE;
      S_ISSUE:        if (last_tap) state_d = S_DRAIN;
      S_DRAIN:        state_d = S_WRITE;
      S_WRITE:        state_d = last_out ? S_DONE : S_ISSUE;
      default:        state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_comb begin
    bus.cmd_ready = idle_like;
    bus.busy      = !idle_like;
    bus.finish    = (state_q == S_DONE);
    bus.done      = done_q;
    bus.res_we    = (state_q == S_WRITE) && !abort;
    if (relu_q && shifted[ACC_WIDTH-1]) bus.res_data = '0;
    else if (shifted > SAT_MAX)         bus.res_data = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN)         bus.res_data = SAT_MIN[DATA_WIDTH-1:0];
    else                                bus.res_data = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kx_q <= '0; ky_q <= '0; ch_q <= '0;
      ox_q <= '0; oy_q <= '0; kn_q <= '0;
      relu_q <= 1'b0;
    end else if (accept) begin
      kx_q <= '0; ky_q <= '0; ch_q <= '0;
      ox_q <= '0; oy_q <= '0; kn_q <= '0;
      relu_q <= (bus.command == CMD_START_RELU);
    end else if (!abort) begin
      if (state_q == S_ISSUE && !last_tap) begin
        if (kx_q != K_MAX) kx_q <= kx_q + CW'(1);
        else begin
          kx_q <= '0;
          if (ky_q != K_MAX) ky_q <= ky_q + CW'(1);
          else begin
            ky_q <= '0;
            ch_q <= ch_q + CW'(1);
          end
        end
      end
      if (state_q == S_WRITE && !last_out) begin
        kx_q <= '0; ky_q <= '0; ch_q <= '0;
        if (ox_q != OX_MAX) ox_q <= ox_q + CW'(1);
        else begin
          ox_q <= '0;
          if (oy_q != OY_MAX) oy_q <= oy_q + CW'(1);
          else begin
            oy_q <= '0;
            kn_q <= kn_q + CW'(1);
          end
        end
      end
    end
  end

  // Memory data lags its address by one cycle; vld_q/first_q track the tap whose data is arriving.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= '0;
    end else begin
      vld_q   <= (state_q == S_ISSUE) && !abort;
      first_q <= (kx_q == '0) && (ky_q == '0) && (ch_q == '0);
      done_q  <= (state_q == S_WRITE) && (state_d == S_DONE);
      if (vld_q) acc_q <= first_q ? prod_ext : acc_q + prod_ext;
    end
  end
endmodule
